// File: rtl/reg_pkg.sv
// Shared register-file constants and dump FSM state encoding.
// Imported by the register dump reader and its bench.
package reg_pkg;

  localparam int REG_ADDR_W   = 3;
  localparam int REG_DATA_W   = 8;
  localparam int NUM_REGS_MAX = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND_HDR,
    S_SEND_REG,
    S_SEND_SUM,
    S_DONE
  } dump_state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Snapshots the register file two registers per cycle, then streams
// a framed dump (header, registers, XOR checksum) over valid/ready.
module reg_dump_reader
  import reg_pkg::*;
#(
  parameter logic [7:0] HEADER   = 8'hA5,
  parameter int         NUM_REGS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [REG_ADDR_W-1:0] rd_addr1,
  output logic [REG_ADDR_W-1:0] rd_addr2,
  input  logic [REG_DATA_W-1:0] rd_data1,
  input  logic [REG_DATA_W-1:0] rd_data2,
  output logic [REG_DATA_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] LAST_PAIR = 2'(NUM_REGS / 2 - 1);
  localparam logic [2:0] LAST_BYTE = 3'(NUM_REGS - 1);

  dump_state_e           state_q, state_d;
  logic [1:0]            pair_q, pair_d;
  logic [2:0]            idx_q, idx_d;
  logic [REG_DATA_W-1:0] sum_q, sum_d;
  logic [REG_DATA_W-1:0] snap_q [NUM_REGS_MAX];
  logic                  fetch_en;

  // State, index and checksum registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pair_q  <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  // Snapshot buffer: one register pair captured per FETCH cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS_MAX; i++) begin
        snap_q[i] <= '0;
      end
    end else if (fetch_en) begin
      snap_q[{pair_q, 1'b0}] <= rd_data1;
      snap_q[{pair_q, 1'b1}] <= rd_data2;
    end
  end

  // Next-state and output decode; outputs depend on state only,
  // so a stalled byte holds steady until accepted.
  always_comb begin
    state_d   = state_q;
    pair_d    = pair_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    fetch_en  = 1'b0;
    rd_addr1  = '0;
    rd_addr2  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_FETCH;
          pair_d  = '0;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      S_FETCH: begin
        fetch_en = 1'b1;
        rd_addr1 = {pair_q, 1'b0};
        rd_addr2 = {pair_q, 1'b1};
        sum_d    = sum_q ^ rd_data1 ^ rd_data2;
        if (pair_q == LAST_PAIR) begin
          state_d = S_SEND_HDR;
        end else begin
          pair_d = pair_q + 2'd1;
        end
      end
      S_SEND_HDR: begin
        out_valid = 1'b1;
        out_data  = HEADER;
        if (out_ready) begin
          state_d = S_SEND_REG;
          idx_d   = '0;
        end
      end
      S_SEND_REG: begin
        out_valid = 1'b1;
        out_data  = snap_q[idx_q];
        if (out_ready) begin
          if (idx_q == LAST_BYTE) begin
            state_d = S_SEND_SUM;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_SEND_SUM: begin
        out_valid = 1'b1;
        out_data  = sum_q;
        if (out_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: register file model with R0 tied to
// zero, scoreboard of expected frame bytes popped on each handshake.
module tb_reg_dump_reader;
  import reg_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       out_ready;
  logic [2:0] rd_addr1, rd_addr2;
  logic [7:0] rd_data1, rd_data2;
  logic [7:0] out_data;
  logic       out_valid, busy, done;

  logic [7:0] rf [8];
  logic [7:0] sb [$];

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int n_done = 0;

  assign rd_data1 = rf[rd_addr1];
  assign rd_data2 = rf[rd_addr2];

  always #5 clk = ~clk;

  reg_dump_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  // Scoreboard monitor: pops on handshake, checks hold under stall.
  initial begin
    bit         pend;
    logic [7:0] held;
    logic [7:0] exp;
    pend = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== held) begin
            errors++;
            $display("FAIL stall_hold: valid=%b data=%h, need 1 %h",
                     out_valid, out_data, held);
          end
        end
        if (done === 1'b1) n_done++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          n_acc++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got %h, none expected", out_data);
          end else begin
            exp = sb.pop_front();
            if (out_data !== exp) begin
              errors++;
              $display("FAIL sb_byte: got %h, expected %h",
                       out_data, exp);
            end
          end
        end
        pend = (out_valid === 1'b1) && (out_ready !== 1'b1);
        held = out_data;
      end
    end
  end

  task automatic rf_write(input int a, input logic [7:0] d);
    if (a != 0) rf[a] = d;
  endtask

  task automatic push_frame();
    logic [7:0] s;
    s = 8'h00;
    sb.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      sb.push_back(rf[i]);
      s = s ^ rf[i];
    end
    sb.push_back(s);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%h, need 0 00",
               out_valid, out_data);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b, need 0 0",
               busy, done);
    end
    checks++;
    if (rd_addr1 !== 3'd0 || rd_addr2 !== 3'd0) begin
      errors++;
      $display("FAIL reset_addr: a1=%0d a2=%0d, need 0 0",
               rd_addr1, rd_addr2);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp37 [10];
    logic [2:0] ea1, ea2;
    logic       ev, ed, eb;
    int         ba, bd;
    exp37 = '{8'hA5, 8'h00, 8'hAA, 8'h00, 8'h55,
              8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    rf_write(1, 8'hAA);
    rf_write(3, 8'h55);
    rf_write(0, 8'hFF);
    for (int i = 0; i < 10; i++) sb.push_back(exp37[i]);
    ba = n_acc;
    bd = n_done;
    pulse_start();
    for (int c = 1; c <= 20; c++) begin
      ea1 = (c <= 4) ? 3'(2 * (c - 1)) : 3'd0;
      ea2 = (c <= 4) ? 3'(2 * (c - 1) + 1) : 3'd0;
      ev  = (c >= 5 && c <= 14);
      ed  = (c == 15);
      eb  = (c <= 15);
      checks++;
      if (rd_addr1 !== ea1 || rd_addr2 !== ea2) begin
        errors++;
        $display("FAIL fetch_addr c=%0d: %0d,%0d need %0d,%0d",
                 c, rd_addr1, rd_addr2, ea1, ea2);
      end
      checks++;
      if (out_valid !== ev) begin
        errors++;
        $display("FAIL valid_window c=%0d: %b need %b",
                 c, out_valid, ev);
      end
      checks++;
      if (done !== ed || busy !== eb) begin
        errors++;
        $display("FAIL done_busy c=%0d: %b%b need %b%b",
                 c, done, busy, ed, eb);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n_acc - ba !== 10 || n_done - bd !== 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL basic_count: acc=%0d done=%0d left=%0d need 10 1 0",
               n_acc - ba, n_done - bd, sb.size());
    end
  endtask

  task automatic test_stall();
    int ba, bd, stalls;
    push_frame();
    ba = n_acc;
    bd = n_done;
    stalls = 0;
    pulse_start();
    for (int cyc = 0; cyc < 200 && n_done == bd; cyc++) begin
      if (n_acc - ba == 3 && out_valid && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = (cyc % 2 == 0);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    checks++;
    if (n_acc - ba !== 10 || n_done - bd !== 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_count: acc=%0d done=%0d left=%0d need 10 1 0",
               n_acc - ba, n_done - bd, sb.size());
    end
  endtask

  task automatic test_snapshot();
    int ba, bd;
    push_frame();
    ba = n_acc;
    bd = n_done;
    pulse_start();
    for (int i = 0; i < 40 && n_acc - ba < 2; i++) begin
      @(posedge clk); #1;
    end
    rf_write(1, 8'hFF);
    for (int i = 0; i < 40 && n_done == bd; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (n_acc - ba !== 10 || n_done - bd !== 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL snap_count: acc=%0d done=%0d left=%0d need 10 1 0",
               n_acc - ba, n_done - bd, sb.size());
    end
    rf_write(1, 8'hAA);
  endtask

  task automatic test_start_ignored();
    int   ba, bd, falls;
    logic pb;
    push_frame();
    ba = n_acc;
    bd = n_done;
    falls = 0;
    pb = 1'b1;
    pulse_start();
    for (int c = 1; c <= 25; c++) begin
      if (busy === 1'b0 && pb === 1'b1) falls++;
      pb = busy;
      if (c >= 16) begin
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL restart c=%0d: valid=%b busy=%b need 0 0",
                   c, out_valid, busy);
        end
      end
      start = (c == 2 || c == 8 || c == 15);
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (falls !== 1 || n_acc - ba !== 10 || n_done - bd !== 1) begin
      errors++;
      $display("FAIL ignore_start: falls=%0d acc=%0d done=%0d need 1 10 1",
               falls, n_acc - ba, n_done - bd);
    end
  endtask

  task automatic test_reset_mid();
    int ba, bd, bad;
    push_frame();
    ba = n_acc;
    pulse_start();
    for (int i = 0; i < 40 && n_acc - ba < 5; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (n_acc - ba !== 5) begin
      errors++;
      $display("FAIL reach_byte5: acc=%0d need 5", n_acc - ba);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b need 0 0",
               out_valid, busy);
    end
    sb.delete();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL abandoned: %0d active cycles, need 0", bad);
    end
    push_frame();
    ba = n_acc;
    bd = n_done;
    pulse_start();
    for (int i = 0; i < 40 && n_done == bd; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (n_acc - ba !== 10 || n_done - bd !== 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL post_reset: acc=%0d done=%0d left=%0d need 10 1 0",
               n_acc - ba, n_done - bd, sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    test_reset();
    test_basic();
    test_stall();
    test_snapshot();
    test_start_ignored();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter HEADER, default 8'hA5: first byte of every dump frame.
REQ-002 Parameter NUM_REGS, default 8: registers dumped; SHALL be even, 2..8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  single-cycle request to snapshot and stream the register file.
REQ-006 rd_addr1  output  3  register file read port 1 address.
REQ-007 rd_addr2  output  3  register file read port 2 address.
REQ-008 rd_data1  input  8  read port 1 data, combinational from rd_addr1.
REQ-009 rd_data2  input  8  read port 2 data, combinational from rd_addr2.
REQ-010 out_data  output  8  streamed frame byte.
REQ-011 out_valid  output  1  out_data holds a valid byte.
REQ-012 out_ready  input  1  sink accepts a byte when out_valid && out_ready.
REQ-013 busy  output  1  high from the cycle after an accepted start until done.
REQ-014 done  output  1  one-cycle pulse after the last frame byte is accepted.

Function
REQ-015 FSM states: IDLE, FETCH, SEND_HDR, SEND_REG, SEND_SUM, DONE.
REQ-016 IDLE: start=1 -> FETCH with pair index 0; start=0 -> stay.
REQ-017 FETCH: drive rd_addr1=2k, rd_addr2=2k+1 for pair k; capture rd_data1/rd_data2 into snapshot buffer at the end of the same cycle.
REQ-018 FETCH lasts exactly NUM_REGS/2 cycles (4 for default), then -> SEND_HDR.
REQ-019 Outside FETCH, rd_addr1 and rd_addr2 SHALL be 3'd0.
REQ-020 Frame order: HEADER, reg[0]..reg[NUM_REGS-1], checksum; 10 bytes for default.
REQ-021 Checksum = XOR of all captured register bytes; HEADER excluded.
REQ-022 out_valid high in SEND_HDR, SEND_REG, SEND_SUM; low in all other states.
REQ-023 While out_valid && !out_ready, out_data and out_valid SHALL hold unchanged.
REQ-024 Each accepted handshake advances exactly one byte; no byte skipped or repeated.
REQ-025 First byte (HEADER) valid in the cycle after FETCH ends; zero stall with out_ready=1 gives one byte per cycle.
REQ-026 Acceptance of checksum -> DONE; DONE asserts done for one cycle, then -> IDLE.
REQ-027 start while not IDLE SHALL be ignored (no restart, no queueing).
REQ-028 start in the DONE cycle SHALL be ignored; new start accepted from IDLE only.
REQ-029 Snapshot is frozen after FETCH; register file changes during streaming do not alter the frame.
REQ-030 busy = 1 in FETCH, SEND_*, DONE; 0 in IDLE.

Reset
REQ-031 rst=1 on a rising edge -> IDLE regardless of state, including mid-FETCH or mid-frame.
REQ-032 Reset values: out_valid=0, out_data=8'h00, busy=0, done=0, rd_addr1=rd_addr2=3'd0.
REQ-033 Reset clears snapshot buffer, byte index, pair index and checksum to 0.
REQ-034 An in-flight frame is abandoned on reset; no further bytes emitted until a new start.

Structure
REQ-035 Shared package reg_pkg SHALL hold REG_ADDR_W=3, REG_DATA_W=8, NUM_REGS_MAX=8 and the dump FSM state enum.
REQ-036 Single flat module; no sub-module; connects directly to RegisterFile read ports.

Verification
REQ-037 Regfile model R1=AA, R3=55, rest 00; start, out_ready=1 -> bytes A5 00 AA 00 55 00 00 00 00 FF, one per cycle, done pulse once.
REQ-038 Same contents, out_ready toggling 1010..., 3-cycle stall on byte 3 -> identical byte sequence, out_data stable during stalls.
REQ-039 Model writes R1=FF during SEND_REG -> frame still carries AA at byte 2, checksum FF.
REQ-040 start pulsed in FETCH, SEND_REG and DONE -> exactly one frame, busy drops once.
REQ-041 rst asserted at byte 5 -> next cycle out_valid=0, busy=0; subsequent start yields full correct 10-byte frame.
REQ-042 Model attempts R0=FF (held 00) -> reg[0] byte = 00; rd_addr pairs observed (0,1),(2,3),(4,5),(6,7) in FETCH.
